// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper half of the
// accumulator, then shift {carry, accumulator} right by one.
module seq_mult_step
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [prod_w(WIDTH)-1:0] acc_i,
    input  logic [WIDTH-1:0]         mcand_i,
    output logic [prod_w(WIDTH)-1:0] acc_o
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    always_comb begin
        addend = acc_i[0] ? {1'b0, mcand_i} : '0;
        // W+1-bit sum keeps the carry so (2^W-1)^2 comes out exact.
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + addend;
        acc_o  = {sum, acc_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier with valid/ready on both sides, one multiplier bit per cycle.
// Define SEQ_MULT_SIGNED_EN to add the is_signed_i port for two's-complement operands.
module seq_shift_add_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         a_i,
    input  logic [WIDTH-1:0]         b_i,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                     is_signed_i,
`endif
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [prod_w(WIDTH)-1:0] p_o,
    output logic                     busy_o
);

    localparam int unsigned    ProdW   = prod_w(WIDTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [ProdW-1:0]   acc_q, acc_d;
    logic [ProdW-1:0]   p_q, p_d;
    logic [ProdW-1:0]   acc_step;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               neg_in;
`ifdef SEQ_MULT_SIGNED_EN
    logic               neg_q, neg_d;
`endif

    seq_mult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i  (acc_q),
        .mcand_i(mcand_q),
        .acc_o  (acc_step)
    );

    // Operand conditioning at acceptance: magnitudes plus the product sign in signed mode.
    always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
        op_a   = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        op_b   = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        neg_in = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`else
        op_a   = a_i;
        op_b   = b_i;
        neg_in = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        p_d         = p_q;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d       = neg_q;
`endif
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) begin
                    mcand_d = op_a;
                    acc_d   = {{WIDTH{1'b0}}, op_b};
                    cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d   = neg_in;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
`ifdef SEQ_MULT_SIGNED_EN
                    p_d = neg_q ? -acc_step : acc_step;
`else
                    p_d = acc_step;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign p_o = p_q;

    // neg_in only feeds state in the signed build.
`ifndef SEQ_MULT_SIGNED_EN
    logic unused_neg;
    assign unused_neg = neg_in;
`endif

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier at WIDTH=8, 2 and 16.
// Signed scenarios are compiled in when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv8, rdy8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv2, rdy2, ov2, or2, busy2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;

    logic        iv16, rdy16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

`ifdef SEQ_MULT_SIGNED_EN
    logic is_s8, is_s2, is_s16;
`endif

    int errors = 0;
    int checks = 0;

    seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(rdy8), .a_i(a8), .b_i(b8),
`ifdef SEQ_MULT_SIGNED_EN
        .is_signed_i(is_s8),
`endif
        .out_valid_o(ov8), .out_ready_i(or8), .p_o(p8), .busy_o(busy8)
    );

    seq_shift_add_multiplier #(.WIDTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv2), .in_ready_o(rdy2), .a_i(a2), .b_i(b2),
`ifdef SEQ_MULT_SIGNED_EN
        .is_signed_i(is_s2),
`endif
        .out_valid_o(ov2), .out_ready_i(or2), .p_o(p2), .busy_o(busy2)
    );

    seq_shift_add_multiplier #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv16), .in_ready_o(rdy16), .a_i(a16), .b_i(b16),
`ifdef SEQ_MULT_SIGNED_EN
        .is_signed_i(is_s16),
`endif
        .out_valid_o(ov16), .out_ready_i(or16), .p_o(p16), .busy_o(busy16)
    );

    // Drives one WIDTH=8 acceptance from IDLE and returns edges-to-out_valid and p at that point.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [15:0] p);
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = p8;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b expected=1", rdy8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b expected=0", ov8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", busy8); end
        checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_p got=%h expected=0000", p8); end
        checks++; if (rdy2 !== 1'b1 || rdy16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_w2_w16 got=%b%b expected=11", rdy2, rdy16); end
    endtask

    task automatic test_max;
        int lat;
        logic [15:0] p;
        or8 = 1'b1;
        run8(8'hFF, 8'hFF, lat, p);
        checks++; if (lat !== 8) begin errors++; $display("FAIL max_latency got=%0d expected=8", lat); end
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL max_product got=%h expected=fe01", p); end
        checks++; if (rdy8 !== 1'b0 || busy8 !== 1'b1) begin errors++; $display("FAIL done_flags got ready=%b busy=%b expected ready=0 busy=1", rdy8, busy8); end
        @(posedge clk); #1;
        checks++; if (rdy8 !== 1'b1 || ov8 !== 1'b0) begin errors++; $display("FAIL post_handshake got ready=%b valid=%b expected ready=1 valid=0", rdy8, ov8); end
        checks++; if (p8 !== 16'hFE01) begin errors++; $display("FAIL p_hold got=%h expected=fe01", p8); end
    endtask

    task automatic test_zero_and_small;
        int lat;
        logic [15:0] p;
        or8 = 1'b1;
        run8(8'h00, 8'hA5, lat, p);
        @(posedge clk); #1;
        checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency got=%0d expected=8", lat); end
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_product got=%h expected=0000", p); end
        run8(8'h0D, 8'h0B, lat, p);
        @(posedge clk); #1;
        checks++; if (p !== 16'h008F) begin errors++; $display("FAIL small_product got=%h expected=008f", p); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  ra, rb;
            logic [15:0] ev;
            ra = 8'($urandom());
            rb = 8'($urandom());
            ev = 16'(ra) * 16'(rb);
            run8(ra, rb, lat, p);
            @(posedge clk); #1;
            checks++; if (p !== ev || lat !== 8) begin errors++; $display("FAIL rand8 a=%h b=%h got=%h lat=%0d expected=%h lat=8", ra, rb, p, lat, ev); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [15:0] p;
        logic [15:0] ev;
        ev  = 16'(8'h37) * 16'(8'h5A);
        or8 = 1'b0;
        run8(8'h37, 8'h5A, lat, p);
        a8  = 8'h11;
        b8  = 8'h22;
        iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (ov8 !== 1'b1 || p8 !== ev || rdy8 !== 1'b0) begin errors++; $display("FAIL backpressure_hold cyc=%0d got valid=%b p=%h ready=%b expected valid=1 p=%h ready=0", i, ov8, p8, rdy8, ev); end
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        checks++; if (ov8 !== 1'b0 || rdy8 !== 1'b1 || p8 !== ev) begin errors++; $display("FAIL backpressure_release got valid=%b ready=%b p=%h expected valid=0 ready=1 p=%h", ov8, rdy8, p8, ev); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy8 !== 1'b0 || ov8 !== 1'b0) begin errors++; $display("FAIL ignored_operand got busy=%b valid=%b expected busy=0 valid=0", busy8, ov8); end
    endtask

    task automatic test_mid_run_reset;
        int lat;
        logic [15:0] p;
        or8 = 1'b1;
        a8  = 8'h77;
        b8  = 8'h99;
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ov8 !== 1'b0 || rdy8 !== 1'b1 || p8 !== 16'h0 || busy8 !== 1'b0) begin errors++; $display("FAIL mid_run_reset got valid=%b ready=%b p=%h busy=%b expected 0 1 0000 0", ov8, rdy8, p8, busy8); end
        run8(8'd3, 8'd2, lat, p);
        @(posedge clk); #1;
        checks++; if (p !== 16'd6) begin errors++; $display("FAIL after_reset_product got=%h expected=0006", p); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] q[$];
        int sent, got, cyc;
        logic acc, hs;
        logic [15:0] pv, ev;
        sent = 0; got = 0; cyc = 0;
        a8 = 8'($urandom());
        b8 = 8'($urandom());
        iv8 = 1'b1;
        while (got < 100 && cyc < 5000) begin
            or8 = 1'($urandom_range(0, 1));
            acc = iv8 & rdy8;
            hs  = ov8 & or8;
            pv  = p8;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back(16'(a8) * 16'(b8));
                sent++;
                if (sent < 100) begin a8 = 8'($urandom()); b8 = 8'($urandom()); end
                else iv8 = 1'b0;
            end
            if (hs) begin
                got++;
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL b2b8_extra got=%h expected=none", pv); end
                else begin
                    ev = q.pop_front();
                    if (pv !== ev) begin errors++; $display("FAIL b2b8_product idx=%0d got=%h expected=%h", got, pv, ev); end
                end
            end
        end
        iv8 = 1'b0;
        or8 = 1'b0;
        checks++; if (got !== 100 || q.size() !== 0) begin errors++; $display("FAIL b2b8_count got=%0d pending=%0d expected=100 pending=0", got, q.size()); end
    endtask

    task automatic test_w2_exhaustive;
        logic [3:0] q[$];
        int sent, got, cyc;
        logic acc, hs;
        logic [3:0] pv, ev, idx;
        sent = 0; got = 0; cyc = 0; idx = 4'd0;
        a2 = idx[3:2];
        b2 = idx[1:0];
        iv2 = 1'b1;
        while (got < 16 && cyc < 2000) begin
            or2 = 1'($urandom_range(0, 1));
            acc = iv2 & rdy2;
            hs  = ov2 & or2;
            pv  = p2;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back(4'(a2) * 4'(b2));
                sent++;
                idx = idx + 4'd1;
                a2 = idx[3:2];
                b2 = idx[1:0];
                if (sent >= 16) iv2 = 1'b0;
            end
            if (hs) begin
                got++;
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL w2_extra got=%h expected=none", pv); end
                else begin
                    ev = q.pop_front();
                    if (pv !== ev) begin errors++; $display("FAIL w2_product idx=%0d got=%h expected=%h", got, pv, ev); end
                end
            end
        end
        iv2 = 1'b0;
        or2 = 1'b0;
        checks++; if (got !== 16 || q.size() !== 0) begin errors++; $display("FAIL w2_count got=%0d pending=%0d expected=16 pending=0", got, q.size()); end
    endtask

    task automatic test_w16_random;
        logic [31:0] q[$];
        int sent, got, cyc;
        logic acc, hs;
        logic [31:0] pv, ev;
        sent = 0; got = 0; cyc = 0;
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        iv16 = 1'b1;
        while (got < 30 && cyc < 5000) begin
            or16 = 1'($urandom_range(0, 1));
            acc = iv16 & rdy16;
            hs  = ov16 & or16;
            pv  = p16;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back(32'(a16) * 32'(b16));
                sent++;
                if (sent < 30) begin a16 = 16'($urandom()); b16 = 16'($urandom()); end
                else iv16 = 1'b0;
            end
            if (hs) begin
                got++;
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL w16_extra got=%h expected=none", pv); end
                else begin
                    ev = q.pop_front();
                    if (pv !== ev) begin errors++; $display("FAIL w16_product idx=%0d got=%h expected=%h", got, pv, ev); end
                end
            end
        end
        iv16 = 1'b0;
        or16 = 1'b0;
        checks++; if (got !== 30 || q.size() !== 0) begin errors++; $display("FAIL w16_count got=%0d pending=%0d expected=30 pending=0", got, q.size()); end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed;
        int lat;
        logic [15:0] p;
        or8 = 1'b1;
        is_s8 = 1'b1;
        run8(8'hFD, 8'h05, lat, p);
        @(posedge clk); #1;
        checks++; if (p !== 16'hFFF1 || lat !== 8) begin errors++; $display("FAIL signed_neg3x5 got=%h lat=%0d expected=fff1 lat=8", p, lat); end
        run8(8'h80, 8'h80, lat, p);
        @(posedge clk); #1;
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL signed_minmin got=%h expected=4000", p); end
        is_s8 = 1'b0;
        run8(8'hFD, 8'h05, lat, p);
        @(posedge clk); #1;
        checks++; if (p !== 16'h04F1) begin errors++; $display("FAIL unsigned_fdx5 got=%h expected=04f1", p); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0]  ra, rb;
            logic [15:0] ev;
            int sa, sb;
            ra = 8'($urandom());
            rb = 8'($urandom());
            is_s8 = 1'($urandom_range(0, 1));
            sa = is_s8 ? int'($signed(ra)) : int'(ra);
            sb = is_s8 ? int'($signed(rb)) : int'(rb);
            ev = 16'(sa * sb);
            run8(ra, rb, lat, p);
            @(posedge clk); #1;
            checks++; if (p !== ev) begin errors++; $display("FAIL signed_rand s=%b a=%h b=%h got=%h expected=%h", is_s8, ra, rb, p, ev); end
        end
        is_s8 = 1'b0;
        or8 = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        iv8 = 1'b0;  or8 = 1'b0;  a8 = '0;  b8 = '0;
        iv2 = 1'b0;  or2 = 1'b0;  a2 = '0;  b2 = '0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        is_s8 = 1'b0; is_s2 = 1'b0; is_s16 = 1'b0;
`endif
        test_reset();
        test_max();
        test_zero_and_small();
        test_backpressure();
        test_mid_run_reset();
        test_back_to_back();
        test_w2_exhaustive();
        test_w16_random();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
